data_cache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage (32-bit word accesses) and the 128-bit block-interface data memory.
- Acts as the initiator of the memory READ/WRITE/BUSYWAIT block protocol.
  - Issues 16-byte block fetches and write-backs.
  - Stalls the CPU through C_BUSYWAIT until each miss is resolved.

---
 rtl/data_cache_controller.sv | 173 +++++++++++++++++
 tb/tb_data_cache_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache.
// CPU side: 32-bit word accesses with byte strobes. Memory side: 128-bit
// block transfers using a READ/WRITE/BUSYWAIT handshake.
module data_cache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         C_READ,
  input  logic         C_WRITE,
  input  logic [31:0]  C_ADDRESS,
  input  logic [31:0]  C_WRITEDATA,
  input  logic [3:0]   C_WSTRB,
  output logic [31:0]  C_READDATA,
  output logic         C_BUSYWAIT,
  output logic         M_READ,
  output logic         M_WRITE,
  output logic [27:0]  M_ADDRESS,
  output logic [127:0] M_WRITEDATA,
  input  logic [127:0] M_READDATA,
  input  logic         M_BUSYWAIT
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic               m_read_q, m_read_d;
  logic               m_write_q, m_write_d;
  logic [27:0]        m_address_q, m_address_d;
  logic [127:0]       m_writedata_q, m_writedata_d;
  logic [27:0]        miss_addr_q, miss_addr_d;

  // Tag and data storage are not reset: only valid/dirty define line state.
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [127:0]       data_mem [LINES];

  logic                  req;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            word_sel;
  logic                  hit;
  logic [127:0]          cur_line;
  logic [127:0]          merged_line;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_W-1:0]      miss_tag;

  logic                  line_we;
  logic                  tag_we;
  logic [INDEX_BITS-1:0] line_widx;
  logic [127:0]          line_wdata;

  // Simultaneous read and write is illegal and is treated as idle.
  assign req      = C_READ ^ C_WRITE;
  assign idx      = C_ADDRESS[3+INDEX_BITS:4];
  assign tag      = C_ADDRESS[31:4+INDEX_BITS];
  assign word_sel = C_ADDRESS[3:2];
  assign cur_line = data_mem[idx];
  assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
  assign miss_idx = miss_addr_q[INDEX_BITS-1:0];
  assign miss_tag = miss_addr_q[27:INDEX_BITS];

  assign C_READDATA  = cur_line[32*word_sel +: 32];
  assign C_BUSYWAIT  = !RESET && req && ((state_q != IDLE) || !hit);
  assign M_READ      = m_read_q;
  assign M_WRITE     = m_write_q;
  assign M_ADDRESS   = m_address_q;
  assign M_WRITEDATA = m_writedata_q;

  // Byte-merge of store data into the addressed word of the indexed line.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign merged_line[8*gi +: 8] =
      ((word_sel == 2'(gi / 4)) && C_WSTRB[gi % 4]) ? C_WRITEDATA[8*(gi % 4) +: 8]
                                                    : cur_line[8*gi +: 8];
  end

  // Next-state, memory request and line-update decisions.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    miss_addr_d   = miss_addr_q;
    line_we       = 1'b0;
    tag_we        = 1'b0;
    line_widx     = idx;
    line_wdata    = merged_line;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (C_WRITE) begin
              line_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            miss_addr_d = C_ADDRESS[31:4];
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d       = WRITEBACK;
              m_write_d     = 1'b1;
              m_address_d   = {tag_mem[idx], idx};
              m_writedata_d = cur_line;
            end else begin
              state_d     = FETCH;
              m_read_d    = 1'b1;
              m_address_d = C_ADDRESS[31:4];
            end
          end
        end
      end
      WRITEBACK: begin
        // Fetch always uses the address captured at miss detection.
        if (!M_BUSYWAIT) begin
          state_d     = FETCH;
          m_write_d   = 1'b0;
          m_read_d    = 1'b1;
          m_address_d = miss_addr_q;
        end
      end
      FETCH: begin
        if (!M_BUSYWAIT) begin
          state_d  = UPDATE;
          m_read_d = 1'b0;
        end
      end
      UPDATE: begin
        line_we           = 1'b1;
        tag_we            = 1'b1;
        line_widx         = miss_idx;
        line_wdata        = M_READDATA;
        valid_d[miss_idx] = 1'b1;
        dirty_d[miss_idx] = 1'b0;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any in-flight transfer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      miss_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      miss_addr_q   <= miss_addr_d;
    end
  end

  // Line data and tag storage writes (store hits and refills).
  always_ff @(posedge CLK) begin
    if (line_we) data_mem[line_widx] <= line_wdata;
    if (tag_we)  tag_mem[line_widx]  <= miss_tag;
  end
endmodule

// File: tb/tb_data_cache_controller.sv
// Randomised self-checking bench for data_cache_controller with a
// transparent-memory reference model and a shadow of line residency.
module tb_data_cache_controller;
  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         C_READ = 1'b0;
  logic         C_WRITE = 1'b0;
  logic [31:0]  C_ADDRESS = '0;
  logic [31:0]  C_WRITEDATA = '0;
  logic [3:0]   C_WSTRB = '0;
  logic [31:0]  C_READDATA;
  logic         C_BUSYWAIT;
  logic         M_READ;
  logic         M_WRITE;
  logic [27:0]  M_ADDRESS;
  logic [127:0] M_WRITEDATA;
  logic [127:0] M_READDATA = '0;
  logic         M_BUSYWAIT;

  data_cache_controller #(.INDEX_BITS(3)) dut (
    .CLK(CLK), .RESET(RESET), .C_READ(C_READ), .C_WRITE(C_WRITE),
    .C_ADDRESS(C_ADDRESS), .C_WRITEDATA(C_WRITEDATA), .C_WSTRB(C_WSTRB),
    .C_READDATA(C_READDATA), .C_BUSYWAIT(C_BUSYWAIT), .M_READ(M_READ),
    .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model (64 blocks) ----------------
  logic [127:0] mem_blk [64];
  int           mem_lat = 2;
  int           mcnt = 0;
  bit           init_mem = 1'b0;
  int           wb_cnt = 0;
  int           rd_cnt = 0;
  logic [27:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;
  logic [27:0]  rd_addr = '0;
  bit           both_seen = 1'b0;

  assign M_BUSYWAIT = (M_READ || M_WRITE) && (mcnt < mem_lat);

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) begin
        if (i == 4) mem_blk[i] <= {$urandom, $urandom, 32'hAAAAAAAA, 32'hDEADBEEF};
        else        mem_blk[i] <= {$urandom, $urandom, $urandom, $urandom};
      end
      mcnt <= 0;
    end else begin
      if (M_READ && M_WRITE) both_seen <= 1'b1;
      if (M_READ || M_WRITE) begin
        if (mcnt == mem_lat) begin
          mcnt <= 0;
        end else if (mcnt == mem_lat - 1) begin
          if (M_WRITE) begin
            mem_blk[M_ADDRESS[5:0]] <= M_WRITEDATA;
            wb_cnt  <= wb_cnt + 1;
            wb_addr <= M_ADDRESS;
            wb_data <= M_WRITEDATA;
          end else begin
            M_READDATA <= mem_blk[M_ADDRESS[5:0]];
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= M_ADDRESS;
          end
          mcnt <= mem_lat;
        end else begin
          mcnt <= mcnt + 1;
        end
      end else begin
        mcnt <= 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_word [256];  // CPU-visible contents, word addressed
  bit          s_valid [8];
  bit          s_dirty [8];
  int          s_tag   [8];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic rebuild_ref();
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        ref_word[b*4 + w] = mem_blk[b][32*w +: 32];
    for (int i = 0; i < 8; i++) begin
      s_valid[i] = 1'b0;
      s_dirty[i] = 1'b0;
      s_tag[i]   = 0;
    end
  endtask

  // One CPU access with full latency, memory-traffic and data checks.
  task automatic run_access(input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rdata);
    int blk, idx, tg, stall, exp_stall, wb0, rd0, eblk;
    bit hit, do_wb;
    logic [127:0] exp_wb;
    logic [31:0]  exp_rd;
    blk   = int'(addr[9:4]);
    idx   = blk % 8;
    tg    = blk / 8;
    hit   = s_valid[idx] && (s_tag[idx] == tg);
    do_wb = !hit && s_valid[idx] && s_dirty[idx];
    eblk  = s_tag[idx] * 8 + idx;
    for (int w = 0; w < 4; w++) exp_wb[32*w +: 32] = ref_word[(eblk*4 + w) % 256];
    exp_stall = hit ? 0 : (mem_lat + 3 + (do_wb ? mem_lat + 1 : 0));
    exp_rd = ref_word[addr[9:2]];
    wb0 = wb_cnt;
    rd0 = rd_cnt;

    @(negedge CLK);
    C_ADDRESS = addr; C_WRITEDATA = wdata; C_WSTRB = wstrb;
    C_READ = !wr; C_WRITE = wr;
    #1;
    stall = 0;
    while (C_BUSYWAIT === 1'b1 && stall < 100) begin
      @(negedge CLK); #1;
      stall++;
    end
    rdata = C_READDATA;
    n_cmp++;
    if (stall != exp_stall) begin
      n_fail++;
      $display("FAIL stall addr=%h got=%0d exp=%0d", addr, stall, exp_stall);
    end
    if (!wr) begin
      n_cmp++;
      if (C_READDATA !== exp_rd) begin
        n_fail++;
        $display("FAIL readdata addr=%h got=%h exp=%h", addr, C_READDATA, exp_rd);
      end
    end
    @(posedge CLK); #1;
    C_READ = 1'b0; C_WRITE = 1'b0;

    n_cmp++;
    if ((wb_cnt - wb0) != int'(do_wb)) begin
      n_fail++;
      $display("FAIL wb_count addr=%h got=%0d exp=%0d", addr, wb_cnt - wb0, int'(do_wb));
    end
    if (do_wb) begin
      n_cmp++;
      if (wb_addr !== 28'(eblk) || wb_data !== exp_wb) begin
        n_fail++;
        $display("FAIL wb_block got=%h/%h exp=%h/%h", wb_addr, wb_data, 28'(eblk), exp_wb);
      end
    end
    n_cmp++;
    if ((rd_cnt - rd0) != int'(!hit)) begin
      n_fail++;
      $display("FAIL fetch_count addr=%h got=%0d exp=%0d", addr, rd_cnt - rd0, int'(!hit));
    end
    if (!hit) begin
      n_cmp++;
      if (rd_addr !== 28'(blk)) begin
        n_fail++;
        $display("FAIL fetch_addr got=%h exp=%h", rd_addr, 28'(blk));
      end
    end

    s_valid[idx] = 1'b1;
    s_tag[idx]   = tg;
    if (!hit) s_dirty[idx] = 1'b0;
    if (wr) begin
      s_dirty[idx] = 1'b1;
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_word[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    end
    $display("txn %s addr=%h wdata=%h wstrb=%b hit=%0d wb=%0d stall=%0d rdata=%h",
             wr ? "WR" : "RD", addr, wdata, wstrb, hit, do_wb, stall, rdata);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1;
    init_mem = 1'b1;
    repeat (2) @(posedge CLK);
    #1 init_mem = 1'b0;
    @(posedge CLK); #1;
    rebuild_ref();
    n_cmp++;
    if (M_READ !== 1'b0 || M_WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mreq got=%b%b exp=00", M_READ, M_WRITE);
    end
    n_cmp++;
    if (M_ADDRESS !== 28'h0 || M_WRITEDATA !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_maddr got=%h/%h exp=0/0", M_ADDRESS, M_WRITEDATA);
    end
    C_READ = 1'b0;
    #1;
    n_cmp++;
    if (C_BUSYWAIT !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got=%b exp=0", C_BUSYWAIT);
    end
    @(negedge CLK) RESET = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_read_miss();
    logic [31:0] rd;
    mem_lat = 3;
    run_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_miss_data got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd;
    run_access(1'b1, 32'h44, 32'h12345678, 4'b0011, rd);
    run_access(1'b0, 32'h44, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'hAAAA5678) begin
      n_fail++;
      $display("FAIL write_hit_merge got=%h exp=aaaa5678", rd);
    end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd;
    mem_lat = 2;
    run_access(1'b0, 32'hC0, 32'h0, 4'h0, rd);
  endtask

  task automatic test_write_miss();
    logic [31:0] rd, v;
    v = $urandom;
    mem_lat = 1;
    run_access(1'b1, 32'h100, v, 4'b1111, rd);
    run_access(1'b0, 32'h100, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== v) begin
      n_fail++;
      $display("FAIL write_miss_data got=%h exp=%h", rd, v);
    end
  endtask

  // Request dropped and address changed mid-miss: refill still completes.
  task automatic test_drop_request();
    logic [31:0] rd;
    int rd0, wb0;
    mem_lat = 2;
    rd0 = rd_cnt;
    wb0 = wb_cnt;
    @(negedge CLK);
    C_ADDRESS = 32'h2A4; C_READ = 1'b1; C_WRITE = 1'b0;
    @(negedge CLK);
    C_ADDRESS = 32'h0; C_READ = 1'b0;
    repeat (mem_lat + 5) @(negedge CLK);
    n_cmp++;
    if (rd_cnt - rd0 != 1 || rd_addr !== 28'd42 || wb_cnt != wb0) begin
      n_fail++;
      $display("FAIL drop_request got=%0d/%h/%0d exp=1/02a/0", rd_cnt - rd0, rd_addr, wb_cnt - wb0);
    end
    s_valid[2] = 1'b1; s_tag[2] = 5; s_dirty[2] = 1'b0;
    $display("txn drop_request addr=000002a4");
    run_access(1'b0, 32'h2A4, 32'h0, 4'h0, rd);
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] rd;
    mem_lat = 4;
    run_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    @(negedge CLK);
    C_ADDRESS = 32'h250; C_READ = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (M_READ !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fetch_mread got=%b exp=1", M_READ);
    end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (M_READ !== 1'b0 || M_WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort got=%b%b exp=00", M_READ, M_WRITE);
    end
    C_READ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    rebuild_ref();
    $display("txn reset_mid_fetch");
    run_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    int rd0, wb0;
    rd0 = rd_cnt;
    wb0 = wb_cnt;
    @(negedge CLK);
    C_ADDRESS = 32'h40; C_WRITEDATA = ~ref_word[16]; C_WSTRB = 4'hF;
    C_READ = 1'b1; C_WRITE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (C_BUSYWAIT !== 1'b0 || M_READ !== 1'b0 || M_WRITE !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_idle cyc=%0d got=%b%b%b exp=000", c, C_BUSYWAIT, M_READ, M_WRITE);
      end
      @(negedge CLK);
    end
    C_READ = 1'b0; C_WRITE = 1'b0;
    n_cmp++;
    if (rd_cnt != rd0 || wb_cnt != wb0) begin
      n_fail++;
      $display("FAIL illegal_traffic got=%0d/%0d exp=0/0", rd_cnt - rd0, wb_cnt - wb0);
    end
    $display("txn illegal addr=00000040");
    run_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    for (int i = 0; i < 200; i++) begin
      mem_lat = $urandom_range(1, 3);
      a = {22'h0, 6'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 2'b00};
      run_access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end
    n_cmp++;
    if (both_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mread_mwrite_exclusive got=%b exp=0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_drop_request();
    test_reset_mid_fetch();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
